// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Purpose  : Byte-wide UART transmitter. 8 data bits LSB first, optional
//            odd/even parity and 1 or 2 stop bits. A one-entry holding
//            register behind a valid/ready interface lets consecutive bytes
//            go out with no idle time between frames.
// Ports    : CLK      - system clock, rising edge
//            RST      - asynchronous active-high reset
//            tx_data  - byte to send, captured on accept
//            tx_valid - tx_data is valid
//            tx_ready - holding register empty (accept = tx_valid&&tx_ready)
//            busy     - frame on the line or a byte waiting in the holder
//            TXD      - serial output, idles high
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       TXD
);

    localparam int                c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic              c_stop_last = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [c_baud_w-1:0] baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic                stop_q, stop_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [7:0]          hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;

    logic                w_baud_tc;
    logic                w_load;
    logic                w_accept;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        w_load      = 1'b0;
        txd_d       = 1'b1;

        w_baud_tc = (baud_q == c_baud_last);
        w_accept  = tx_valid && !hold_full_q;

        // Free-running within a state; wrap at terminal count so every bit
        // lasts exactly CLKS_PER_BIT cycles.
        baud_d = w_baud_tc ? '0 : baud_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (hold_full_q) begin
                    w_load  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_tc) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_baud_tc) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (w_baud_tc) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_baud_tc) begin
                    if (stop_q == c_stop_last) begin
                        // Chain straight into the next frame when a byte
                        // is waiting, so there is no idle bit between them.
                        if (hold_full_q) begin
                            w_load  = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        // Parity is fixed at load time from the byte entering the shifter.
        if (w_load) begin
            shift_d = hold_q;
            par_d   = (PARITY == 1) ? ~^hold_q : ^hold_q;
            baud_d  = '0;
        end

        // Load empties the holder; a simultaneous accept refills it.
        if (w_load) begin
            hold_full_d = 1'b0;
        end
        if (w_accept) begin
            hold_full_d = 1'b1;
            hold_d      = tx_data;
        end

        // TXD is registered: decode the line level from the next state.
        case (state_d)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE) || hold_full_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            stop_q      <= 1'b0;
            shift_q     <= 8'd0;
            par_q       <= 1'b0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_ready = !hold_full_q;
    assign busy     = busy_q;
    assign TXD      = txd_q;

endmodule

`default_nettype wire
